// File: rtl/lenet_pkg.sv
// Shared LeNet constants and types.
// Holds the feature word width, the L4 pooled-layer geometry, the L4 reader
// FSM state encodings and the read-tag payload that travels alongside each
// outstanding BRAM read.
package lenet_pkg;

  localparam int unsigned DATA_WIDTH  = 12;
  localparam int unsigned L4_CHANNELS = 16;
  localparam int unsigned L4_MAP_SIZE = 25;
  localparam int unsigned L4_ADDR_W   = 8;
  localparam int unsigned L4_INDEX_W  = 9;

  // One-hot reader states
  typedef enum logic [3:0] {
    L4_IDLE  = 4'b0001,
    L4_READ  = 4'b0010,
    L4_DRAIN = 4'b0100,
    L4_DONE  = 4'b1000
  } l4_state_e;

  // Tag carried down the read-latency pipeline
  typedef struct packed {
    logic valid;
    logic bank;
  } l4_rd_tag_t;

endpackage

// File: rtl/l4_stream_fifo.sv
// Synchronous skid FIFO for the L4 feature stream.
// Ports: clk, rst (sync, active-low); push/push_data write side;
// pop/pop_data read side (pop_data shows the head word); full, empty, count.
// Push while full is accepted when a pop happens in the same cycle.
module l4_stream_fifo #(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Storage, pointers and occupancy
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign pop_data = mem[rd_ptr];
  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);

endmodule

// File: rtl/l4_feature_reader.sv
// Streams the 16x5x5 L4 pooled feature maps out of two BRAM banks as a
// flat channel-major sequence (index = c*25 + p).
// Ports: clk, rst (sync, active-low); L4_rd_en start level;
// L4_output_read_addr shared bank address; L4_output_read_data1/2 bank0/bank1
// read data; out_data/out_valid/out_ready/out_index/out_last output stream;
// rd_done high while the reader sits in DONE.
module l4_feature_reader #(
  parameter int unsigned DATA_WIDTH = lenet_pkg::DATA_WIDTH,
  parameter int unsigned CHANNELS   = lenet_pkg::L4_CHANNELS,
  parameter int unsigned MAP_SIZE   = lenet_pkg::L4_MAP_SIZE,
  parameter int unsigned RD_LATENCY = 2,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             L4_rd_en,
  output logic [lenet_pkg::L4_ADDR_W-1:0]  L4_output_read_addr,
  input  logic [DATA_WIDTH-1:0]            L4_output_read_data1,
  input  logic [DATA_WIDTH-1:0]            L4_output_read_data2,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [lenet_pkg::L4_INDEX_W-1:0] out_index,
  output logic                             out_last,
  output logic                             rd_done
);

  import lenet_pkg::*;

  localparam int unsigned TOTAL   = CHANNELS * MAP_SIZE;
  localparam int unsigned ADDR_W  = L4_ADDR_W;
  localparam int unsigned INDEX_W = L4_INDEX_W;
  localparam int unsigned CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned POS_W   = (MAP_SIZE > 1) ? $clog2(MAP_SIZE) : 1;
  localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned FL_W    = $clog2(RD_LATENCY + 2);
  localparam int unsigned CR_W    = CNT_W + FL_W + 1;

  l4_state_e             state;
  l4_state_e             state_next;
  logic [CH_W-1:0]       ch;
  logic [POS_W-1:0]      pos;
  logic [INDEX_W-1:0]    issued;
  logic [ADDR_W-1:0]     addr_q;
  logic [INDEX_W-1:0]    index_q;
  logic                  last_seen;
  l4_rd_tag_t            tag [RD_LATENCY + 1];
  logic [FL_W-1:0]       in_flight;
  logic                  issue;
  logic                  xfer;
  logic                  push;
  logic [DATA_WIDTH-1:0] push_data;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [CNT_W-1:0]      fifo_count;

  // Reads issued but not yet landed in the FIFO (including the one landing now)
  always_comb begin
    in_flight = '0;
    for (int unsigned i = 0; i <= RD_LATENCY; i++) begin
      in_flight = in_flight + FL_W'(tag[i].valid);
    end
  end

  assign xfer = out_valid && out_ready;

  // Credit check: a pop this cycle frees a slot, so occupancy + in-flight may
  // reach FIFO_DEPTH while streaming; that keeps one word per cycle.
  assign issue = (state == L4_READ) && (!fifo_full || xfer) &&
                 ((CR_W'(fifo_count) + CR_W'(in_flight)) <
                  (CR_W'(FIFO_DEPTH) + CR_W'(xfer)));

  assign push      = tag[RD_LATENCY].valid;
  assign push_data = tag[RD_LATENCY].bank ? L4_output_read_data2 : L4_output_read_data1;

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state <= L4_IDLE;
    else      state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      L4_IDLE:  if (L4_rd_en) state_next = L4_READ;
      L4_READ:  if (issue && (issued == INDEX_W'(TOTAL - 1))) state_next = L4_DRAIN;
      L4_DRAIN: if ((in_flight == '0) && fifo_empty && last_seen) state_next = L4_DONE;
      L4_DONE:  if (!L4_rd_en) state_next = L4_IDLE;
      default:  state_next = L4_IDLE;
    endcase
  end

  // Address generation, read-tag pipeline and output index
  always_ff @(posedge clk) begin
    if (!rst) begin
      ch        <= '0;
      pos       <= '0;
      issued    <= '0;
      addr_q    <= '0;
      index_q   <= '0;
      last_seen <= 1'b0;
      for (int unsigned i = 0; i <= RD_LATENCY; i++) tag[i] <= '0;
    end else begin
      tag[0] <= l4_rd_tag_t'{valid: issue, bank: ch[0]};
      for (int unsigned i = 1; i <= RD_LATENCY; i++) tag[i] <= tag[i-1];

      if (state == L4_IDLE) begin
        ch     <= '0;
        pos    <= '0;
        issued <= '0;
      end

      if (issue) begin
        // Channel pairs share a bank address; the channel LSB picks the bank
        addr_q <= ADDR_W'(32'(ch >> 1) * MAP_SIZE + 32'(pos));
        issued <= issued + 1'b1;
        if (pos == POS_W'(MAP_SIZE - 1)) begin
          pos <= '0;
          ch  <= ch + 1'b1;
        end else begin
          pos <= pos + 1'b1;
        end
      end

      if (xfer) begin
        if (index_q != INDEX_W'(TOTAL - 1)) index_q   <= index_q + 1'b1;
        else                                last_seen <= 1'b1;
      end

      if ((state == L4_DONE) && !L4_rd_en) begin
        index_q   <= '0;
        last_seen <= 1'b0;
      end
    end
  end

  l4_stream_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (out_ready),
    .pop_data  (out_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign out_valid           = !fifo_empty;
  assign out_index           = index_q;
  assign out_last            = out_valid && (index_q == INDEX_W'(TOTAL - 1));
  assign rd_done             = (state == L4_DONE);
  assign L4_output_read_addr = addr_q;

endmodule

// File: tb/tb_l4_feature_reader.sv
// Self-checking bench for l4_feature_reader: BRAM banks modelled with a
// fixed read latency, output stream compared against a channel-major model.
module tb_l4_feature_reader;

  localparam int unsigned DW     = 12;
  localparam int unsigned RD_LAT = 2;
  localparam int unsigned DEPTH  = 4;
  localparam int          TOTAL  = 400;
  localparam int          MAP    = 25;

  logic          clk;
  logic          rst;
  logic          L4_rd_en;
  logic [7:0]    L4_output_read_addr;
  logic [DW-1:0] L4_output_read_data1;
  logic [DW-1:0] L4_output_read_data2;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic [8:0]    out_index;
  logic          out_last;
  logic          rd_done;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] bank0 [256];
  logic [DW-1:0] bank1 [256];
  logic [7:0]    addr_d [RD_LAT];
  logic [DW-1:0] seen_data [TOTAL];

  int unsigned addr_changes;
  int unsigned addr_seq_err;
  int unsigned addr_max;
  logic [7:0]  last_addr;

  l4_feature_reader #(
    .DATA_WIDTH (DW),
    .CHANNELS   (16),
    .MAP_SIZE   (25),
    .RD_LATENCY (RD_LAT),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .L4_rd_en             (L4_rd_en),
    .L4_output_read_addr  (L4_output_read_addr),
    .L4_output_read_data1 (L4_output_read_data1),
    .L4_output_read_data2 (L4_output_read_data2),
    .out_data             (out_data),
    .out_valid            (out_valid),
    .out_ready            (out_ready),
    .out_index            (out_index),
    .out_last             (out_last),
    .rd_done              (rd_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    for (int k = 0; k < 256; k++) begin
      bank0[k] = DW'(k);
      bank1[k] = DW'(32'h800 + k);
    end
  end

  // BRAM: data reflects the address presented RD_LAT clock edges earlier
  always @(posedge clk) begin
    addr_d[0] <= L4_output_read_addr;
    for (int i = 1; i < RD_LAT; i++) addr_d[i] <= addr_d[i-1];
  end
  assign L4_output_read_data1 = bank0[addr_d[RD_LAT-1]];
  assign L4_output_read_data2 = bank1[addr_d[RD_LAT-1]];

  // Address observer: every new address is the next issue in channel-major order
  always @(negedge clk) begin : addr_mon
    int unsigned k;
    int unsigned c;
    int unsigned p;
    if (rst === 1'b0) begin
      addr_changes = 0;
      addr_seq_err = 0;
      addr_max     = 0;
      last_addr    = 8'd0;
    end else if (L4_output_read_addr !== last_addr) begin
      addr_changes = addr_changes + 1;
      k = addr_changes;
      c = k / MAP;
      p = k % MAP;
      if (L4_output_read_addr !== 8'((c / 2) * MAP + p)) addr_seq_err = addr_seq_err + 1;
      if (int'(L4_output_read_addr) > int'(addr_max)) addr_max = int'(L4_output_read_addr);
      last_addr = L4_output_read_addr;
    end
  end

  // Expected flat word i: channel c, position p, stored in bank c%2 at (c/2)*25+p
  function automatic logic [DW-1:0] exp_word(input int i);
    int c;
    int p;
    int a;
    c = i / MAP;
    p = i % MAP;
    a = (c / 2) * MAP + p;
    return (c % 2 == 1) ? DW'(32'h800 + a) : DW'(a);
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick();
    rst       = 1'b0;
    L4_rd_en  = 1'b0;
    out_ready = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
  endtask

  // mode 0: ready always 1; mode 1: ready 30% random; mode 2: 20-cycle stall after first valid
  task automatic stream_run(input int mode, input bit hold_en, output int xfers);
    int   first_valid_n = -1;
    int   first_xfer_n  = -1;
    int   last_xfer_n   = -1;
    int   stall_left    = 20;
    int   max_occ       = 0;
    int   occ;
    bit   done          = 1'b0;
    bit   stalled_prev  = 1'b0;
    bit   rdy;
    logic [DW-1:0] held_data = '0;
    logic [8:0]    held_idx  = '0;
    xfers = 0;
    tick();
    L4_rd_en  = 1'b1;
    out_ready = 1'b0;
    for (int n = 1; n <= 4000 && !done; n++) begin
      tick();
      if (!hold_en) L4_rd_en = 1'b0;
      occ = int'(addr_changes) + 1 - xfers;
      if (occ > max_occ) max_occ = occ;
      if (out_valid && first_valid_n < 0) first_valid_n = n;
      if (stalled_prev) begin
        checks++;
        if (!out_valid || out_data !== held_data || out_index !== held_idx) begin
          failures++;
          $display("FAIL stable n=%0d got valid=%b data=%h idx=%0d, need valid=1 data=%h idx=%0d",
                   n, out_valid, out_data, out_index, held_data, held_idx);
        end
      end
      rdy = 1'b1;
      if (mode == 1) begin
        rdy = ($urandom_range(0, 99) < 30);
      end else if (mode == 2) begin
        if (first_valid_n < 0) begin
          rdy = 1'b0;
        end else if (stall_left > 0) begin
          rdy = 1'b0;
          stall_left--;
          if (stall_left == 0) begin
            checks++;
            if (!out_valid || out_data !== 12'h000 || addr_changes > 3) begin
              failures++;
              $display("FAIL stall_hold got valid=%b data=%h issues=%0d, need valid=1 data=000 issues<=4",
                       out_valid, out_data, addr_changes + 1);
            end
          end
        end
      end
      out_ready = rdy;
      if (out_valid && rdy) begin
        checks++;
        if (xfers >= TOTAL || out_index !== 9'(xfers) || out_data !== exp_word(xfers) ||
            out_last !== (xfers == TOTAL - 1)) begin
          failures++;
          $display("FAIL word n=%0d got data=%h idx=%0d last=%b, need data=%h idx=%0d last=%b",
                   n, out_data, out_index, out_last, exp_word(xfers), xfers, (xfers == TOTAL - 1));
        end
        if (xfers < TOTAL) seen_data[xfers] = out_data;
        if (first_xfer_n < 0) first_xfer_n = n;
        last_xfer_n = n;
        xfers++;
      end
      stalled_prev = out_valid && !rdy;
      held_data    = out_data;
      held_idx     = out_index;
      if (rd_done) done = 1'b1;
    end
    out_ready = 1'b0;
    checks++;
    if (!done || xfers != TOTAL) begin
      failures++;
      $display("FAIL completion mode=%0d got done=%b xfers=%0d, need done=1 xfers=%0d",
               mode, done, xfers, TOTAL);
    end
    checks++;
    if (addr_seq_err != 0 || addr_changes != TOTAL - 1 || addr_max != 199) begin
      failures++;
      $display("FAIL addr_seq mode=%0d got errs=%0d issues=%0d max=%0d, need errs=0 issues=400 max=199",
               mode, addr_seq_err, addr_changes + 1, addr_max);
    end
    checks++;
    if (max_occ > int'(DEPTH)) begin
      failures++;
      $display("FAIL occupancy mode=%0d got max=%0d, need <=%0d", mode, max_occ, DEPTH);
    end
    if (mode == 0) begin
      checks++;
      if (first_valid_n != int'(RD_LAT) + 3 || first_xfer_n != first_valid_n ||
          last_xfer_n - first_xfer_n != TOTAL - 1) begin
        failures++;
        $display("FAIL timing got first_valid=%0d span=%0d, need first_valid=%0d span=%0d",
                 first_valid_n, last_xfer_n - first_xfer_n, RD_LAT + 3, TOTAL - 1);
      end
    end
  endtask

  task automatic test_reset();
    tick();
    rst       = 1'b0;
    L4_rd_en  = 1'b0;
    out_ready = 1'b0;
    repeat (2) tick();
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got %b need 0", out_valid); end
    checks++;
    if (out_last !== 1'b0) begin failures++; $display("FAIL rst_last got %b need 0", out_last); end
    checks++;
    if (rd_done !== 1'b0) begin failures++; $display("FAIL rst_done got %b need 0", rd_done); end
    checks++;
    if (out_index !== 9'd0) begin failures++; $display("FAIL rst_index got %0d need 0", out_index); end
    checks++;
    if (out_data !== 12'h000) begin failures++; $display("FAIL rst_data got %h need 000", out_data); end
    checks++;
    if (L4_output_read_addr !== 8'd0) begin
      failures++; $display("FAIL rst_addr got %0d need 0", L4_output_read_addr);
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_full_rate();
    int xf;
    do_reset();
    stream_run(0, 1'b0, xf);
    checks++;
    if (seen_data[0] !== 12'h000 || seen_data[25] !== 12'h800 ||
        seen_data[50] !== 12'h019 || seen_data[399] !== 12'h8C7) begin
      failures++;
      $display("FAIL key_words got %h %h %h %h, need 000 800 019 8c7",
               seen_data[0], seen_data[25], seen_data[50], seen_data[399]);
    end
    tick();
    checks++;
    if (rd_done !== 1'b0 || out_index !== 9'd0) begin
      failures++;
      $display("FAIL leave_done got done=%b idx=%0d, need done=0 idx=0", rd_done, out_index);
    end
  endtask

  task automatic test_random_ready();
    int xf;
    do_reset();
    stream_run(1, 1'b0, xf);
  endtask

  task automatic test_stall();
    int xf;
    do_reset();
    stream_run(2, 1'b0, xf);
  endtask

  task automatic test_reset_mid();
    int xfers = 0;
    int bad   = 0;
    int xf;
    do_reset();
    L4_rd_en = 1'b1;
    for (int n = 0; n < 1000 && xfers < 150; n++) begin
      tick();
      L4_rd_en  = 1'b0;
      out_ready = 1'b1;
      if (out_valid) xfers++;
    end
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (xfers != 150 || out_valid !== 1'b0 || rd_done !== 1'b0 || out_index !== 9'd0) begin
      failures++;
      $display("FAIL mid_reset got xfers=%0d valid=%b done=%b idx=%0d, need 150 0 0 0",
               xfers, out_valid, rd_done, out_index);
    end
    rst       = 1'b1;
    out_ready = 1'b1;
    repeat (int'(RD_LAT) + 4) begin
      tick();
      if (out_valid !== 1'b0 || L4_output_read_addr !== 8'd0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL post_reset_idle got %0d active cycles, need 0", bad);
    end
    out_ready = 1'b0;
    stream_run(0, 1'b0, xf);
    checks++;
    if (seen_data[0] !== 12'h000) begin
      failures++;
      $display("FAIL restart_word0 got %h need 000", seen_data[0]);
    end
  endtask

  task automatic test_done_hold();
    int xf;
    int bad = 0;
    do_reset();
    stream_run(0, 1'b1, xf);
    repeat (10) begin
      tick();
      if (rd_done !== 1'b1 || out_valid !== 1'b0 || addr_changes != TOTAL - 1 ||
          L4_output_read_addr !== 8'd199) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL done_hold got %0d bad cycles, need 0", bad);
    end
    L4_rd_en = 1'b0;
    tick();
    checks++;
    if (rd_done !== 1'b0 || out_index !== 9'd0) begin
      failures++;
      $display("FAIL done_release got done=%b idx=%0d, need done=0 idx=0", rd_done, out_index);
    end
  endtask

  initial begin
    rst       = 1'b0;
    L4_rd_en  = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_full_rate();
    test_random_ready();
    test_stall();
    test_reset_mid();
    test_done_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog expired before the bench completed");
    $fatal(1, "watchdog");
  end

endmodule
